// File: rtl/pc_unit_if.sv
// pc_unit_if: bundles the sequencing handshake and branch/decode inputs of
// pc_unit together with its PC/status outputs. The optional CycleCount wire
// exists only when PC_CYCLE_COUNT_EN is defined.
interface pc_unit_if #(
  parameter int PC_W = 10
);
  logic            Start;
  logic [PC_W-1:0] StartAddr;
  logic            Branch;
  logic            BranchDirection;
  logic [7:0]      BranchAmount;
  logic            Halt;
  logic            Stall;
  logic [PC_W-1:0] PC;
  logic            Running;
  logic            Done;
`ifdef PC_CYCLE_COUNT_EN
  logic [15:0]     CycleCount;
`endif

  // Driven by the top level / testbench: start control and decoded fields.
  modport master (
    output Start, StartAddr, Branch, BranchDirection, BranchAmount, Halt, Stall,
`ifdef PC_CYCLE_COUNT_EN
    input  CycleCount,
`endif
    input  PC, Running, Done
  );

  // Seen from the program-counter stage itself.
  modport slave (
    input  Start, StartAddr, Branch, BranchDirection, BranchAmount, Halt, Stall,
`ifdef PC_CYCLE_COUNT_EN
    output CycleCount,
`endif
    output PC, Running, Done
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter and IDLE/RUN/DONE sequencer. Steps the PC each
// run cycle, applies taken branches with a sign-extended 8-bit offset
// (wrapping modulo 2^PC_W), and freezes on Stall. Halt beats Branch.
// Optional feature macro: PC_CYCLE_COUNT_EN adds a saturating 16-bit
// CycleCount of edges spent in RUN.
module pc_unit #(
  parameter int PC_W = 10
) (
  input logic     CLK,
  input logic     init_n,
  pc_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          stateCur;
  state_t          stateNext;
  logic [PC_W-1:0] pcReg;
  logic [PC_W-1:0] pcNext;
  logic [PC_W-1:0] branchOffset;
  logic            startAccepted;

  // Sign-extending size cast; the PC-width add then wraps naturally.
  assign branchOffset  = PC_W'($signed(bus.BranchAmount));
  assign startAccepted = (stateCur != RUN) && bus.Start;

  // State register, forced to IDLE while init_n is low.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      stateCur <= IDLE;
    end else begin
      stateCur <= stateNext;
    end
  end

  // Next state: Start leaves IDLE/DONE, an unstalled Halt leaves RUN.
  always_comb begin
    stateNext = stateCur;
    case (stateCur)
      IDLE:    if (bus.Start) stateNext = RUN;
      RUN:     if (!bus.Stall && bus.Halt) stateNext = DONE;
      DONE:    if (bus.Start) stateNext = RUN;
      default: stateNext = IDLE;
    endcase
  end

  // Status outputs decoded from the state, PC straight from its register.
  always_comb begin
    bus.Running = (stateCur == RUN);
    bus.Done    = (stateCur == DONE);
    bus.PC      = pcReg;
  end

  // Next PC: stall and halt hold, taken branch adds offset, else step by one.
  always_comb begin
    pcNext = pcReg;
    case (stateCur)
      IDLE, DONE: begin
        if (bus.Start) pcNext = bus.StartAddr;
      end
      RUN: begin
        if (bus.Stall || bus.Halt) begin
          pcNext = pcReg;
        end else if (bus.Branch && bus.BranchDirection) begin
          pcNext = pcReg + branchOffset;
        end else begin
          pcNext = pcReg + PC_W'(1);
        end
      end
      default: pcNext = pcReg;
    endcase
  end

  // PC register, cleared asynchronously so a mid-run reset aborts at once.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      pcReg <= '0;
    end else begin
      pcReg <= pcNext;
    end
  end

`ifdef PC_CYCLE_COUNT_EN
  logic [15:0] cycleCnt;

  // Run-length counter: clears on an accepted Start, counts every RUN edge
  // (stalls included), saturates, and so stays readable in DONE.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      cycleCnt <= 16'h0000;
    end else if (startAccepted) begin
      cycleCnt <= 16'h0000;
    end else if ((stateCur == RUN) && (cycleCnt != 16'hFFFF)) begin
      cycleCnt <= cycleCnt + 16'h0001;
    end
  end

  assign bus.CycleCount = cycleCnt;
`else
  logic unusedStart;
  assign unusedStart = startAccepted;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: table-driven directed vectors, hand-written reset/counter
// sequences, and a randomized phase checked against an arithmetic model.
// Build with PC_CYCLE_COUNT_EN defined to also check CycleCount.
module tb_pc_unit;
  localparam int PCW = 10;
  localparam int MEM = 1 << PCW;

  typedef struct {
    logic            start;
    logic [PCW-1:0]  startAddr;
    logic            branch;
    logic            dir;
    logic [7:0]      amt;
    logic            halt;
    logic            stall;
    logic [PCW-1:0]  expPc;
    logic            expRun;
    logic            expDone;
  } vec_t;

  logic CLK = 1'b0;
  logic init_n;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  // Reference model state: plain integers and flags.
  int   mPc;
  bit   mRunning;
  bit   mDone;
  int   mCnt;

  pc_unit_if #(.PC_W(PCW)) bus();

  pc_unit #(.PC_W(PCW)) dut (
    .CLK    (CLK),
    .init_n (init_n),
    .bus    (bus.slave)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic addVec(input logic s, input int sa, input logic b, input logic d,
                        input logic [7:0] amt, input logic h, input logic st,
                        input int ePc, input logic eRun, input logic eDone);
    vec_t v;
    v.start = s; v.startAddr = PCW'(sa); v.branch = b; v.dir = d; v.amt = amt;
    v.halt = h; v.stall = st; v.expPc = PCW'(ePc); v.expRun = eRun; v.expDone = eDone;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, let one rising edge pass, land 1 time unit after it.
  task automatic applyStimulus(input logic s, input int sa, input logic b, input logic d,
                               input logic [7:0] amt, input logic h, input logic st);
    bus.Start           = s;
    bus.StartAddr       = PCW'(sa);
    bus.Branch          = b;
    bus.BranchDirection = d;
    bus.BranchAmount    = amt;
    bus.Halt            = h;
    bus.Stall           = st;
    @(posedge CLK);
    #1;
  endtask

  // Advance the model by one edge from the rules of the sequencer.
  task automatic modelStep(input logic s, input int sa, input logic b, input logic d,
                           input logic [7:0] amt, input logic h, input logic st);
    int off;
    off = (amt >= 8'd128) ? int'(amt) - 256 : int'(amt);
    if (!mRunning) begin
      if (s) begin
        mPc = sa % MEM; mRunning = 1; mDone = 0; mCnt = 0;
      end
    end else begin
      if (mCnt < 65535) mCnt++;
      if (st) begin
        // frozen
      end else if (h) begin
        mRunning = 0; mDone = 1;
      end else if (b && d) begin
        mPc = (mPc + off + MEM) % MEM;
      end else begin
        mPc = (mPc + 1) % MEM;
      end
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".PC"}, 32'(bus.PC), 32'(mPc));
    checkOutput({tag, ".Running"}, 32'(bus.Running), 32'(mRunning));
    checkOutput({tag, ".Done"}, 32'(bus.Done), 32'(mDone));
`ifdef PC_CYCLE_COUNT_EN
    checkOutput({tag, ".CycleCount"}, 32'(bus.CycleCount), 32'(mCnt));
`endif
  endtask

  task automatic stepAndCheck(input string tag, input logic s, input int sa, input logic b,
                              input logic d, input logic [7:0] amt, input logic h, input logic st);
    modelStep(s, sa, b, d, amt, h, st);
    applyStimulus(s, sa, b, d, amt, h, st);
    checkModel(tag);
  endtask

  initial begin
    //        s  sa   b  d  amt    h  st   pc    run done
    addVec(1, 5,   0, 0, 8'h00, 0, 0,  5,    1, 0);
    addVec(0, 0,   0, 0, 8'h00, 0, 0,  6,    1, 0);
    addVec(0, 0,   0, 0, 8'h00, 0, 0,  7,    1, 0);
    addVec(0, 0,   1, 1, 8'h0D, 0, 0,  20,   1, 0);
    addVec(0, 0,   1, 1, 8'hFC, 0, 0,  16,   1, 0);
    addVec(0, 0,   1, 1, 8'h04, 0, 0,  20,   1, 0);
    addVec(0, 0,   1, 0, 8'hFC, 0, 0,  21,   1, 0);
    addVec(0, 0,   1, 1, 8'hEA, 0, 0,  1023, 1, 0);
    addVec(0, 0,   0, 0, 8'h00, 0, 0,  0,    1, 0);
    addVec(0, 0,   0, 0, 8'h00, 0, 0,  1,    1, 0);
    addVec(0, 0,   0, 0, 8'h00, 0, 0,  2,    1, 0);
    addVec(0, 0,   1, 1, 8'hFB, 0, 0,  1021, 1, 0);
    addVec(0, 0,   1, 1, 8'h21, 0, 0,  30,   1, 0);
    addVec(0, 0,   0, 0, 8'h00, 1, 1,  30,   1, 0);
    addVec(0, 0,   0, 0, 8'h00, 1, 1,  30,   1, 0);
    addVec(0, 0,   0, 0, 8'h00, 1, 0,  30,   0, 1);
    addVec(0, 0,   0, 0, 8'h00, 0, 0,  30,   0, 1);
    addVec(1, 100, 0, 0, 8'h00, 0, 0,  100,  1, 0);
    addVec(1, 200, 0, 0, 8'h00, 0, 0,  101,  1, 0);
    addVec(0, 0,   1, 1, 8'h0A, 1, 0,  101,  0, 1);
    addVec(1, 0,   0, 0, 8'h00, 0, 0,  0,    1, 0);
    addVec(0, 0,   1, 1, 8'h00, 0, 0,  0,    1, 0);
    addVec(0, 0,   1, 1, 8'h7F, 0, 0,  127,  1, 0);
    addVec(0, 0,   1, 1, 8'h80, 0, 0,  1023, 1, 0);
    addVec(0, 0,   1, 1, 8'h05, 0, 1,  1023, 1, 0);
    addVec(0, 0,   0, 0, 8'h00, 1, 0,  1023, 0, 1);

    // Reset held for three edges: everything at zero.
    init_n = 1'b0;
    bus.Start = 0; bus.StartAddr = '0; bus.Branch = 0; bus.BranchDirection = 0;
    bus.BranchAmount = '0; bus.Halt = 0; bus.Stall = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      checkOutput($sformatf("reset%0d.PC", i), 32'(bus.PC), 32'd0);
      checkOutput($sformatf("reset%0d.Running", i), 32'(bus.Running), 32'd0);
      checkOutput($sformatf("reset%0d.Done", i), 32'(bus.Done), 32'd0);
`ifdef PC_CYCLE_COUNT_EN
      checkOutput($sformatf("reset%0d.CycleCount", i), 32'(bus.CycleCount), 32'd0);
`endif
    end
    init_n = 1'b1;

    // Directed vector table.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].start, int'(vecs[i].startAddr), vecs[i].branch, vecs[i].dir,
                    vecs[i].amt, vecs[i].halt, vecs[i].stall);
      checkOutput($sformatf("vec%0d.PC", i), 32'(bus.PC), 32'(vecs[i].expPc));
      checkOutput($sformatf("vec%0d.Running", i), 32'(bus.Running), 32'(vecs[i].expRun));
      checkOutput($sformatf("vec%0d.Done", i), 32'(bus.Done), 32'(vecs[i].expDone));
    end

    // Model picks up where the table ended: DONE at 1023, five RUN edges since the last start.
    mPc = 1023; mRunning = 0; mDone = 1; mCnt = 5;
`ifdef PC_CYCLE_COUNT_EN
    checkOutput("table.CycleCount", 32'(bus.CycleCount), 32'd5);
`endif

    // Randomized phase against the model.
    for (int n = 0; n < 600; n++) begin
      logic s, b, d, h, st;
      int sa;
      logic [7:0] amt;
      s   = ($urandom_range(0, 7) == 0);
      sa  = int'($urandom_range(0, MEM - 1));
      b   = 1'($urandom_range(0, 1));
      d   = 1'($urandom_range(0, 1));
      amt = 8'($urandom_range(0, 255));
      h   = ($urandom_range(0, 24) == 0);
      st  = ($urandom_range(0, 5) == 0);
      stepAndCheck($sformatf("rand%0d", n), s, sa, b, d, amt, h, st);
    end

    // Make sure a run is active, then assert reset between edges.
    stepAndCheck("preabort", 1, 300, 0, 0, 8'h00, 0, 0);
    stepAndCheck("preabort2", 0, 0, 0, 0, 8'h00, 0, 0);
    #2;
    init_n = 1'b0;
    #1;
    mPc = 0; mRunning = 0; mDone = 0; mCnt = 0;
    checkModel("abort");
    applyStimulus(1, 9, 0, 0, 8'h00, 0, 0);
    checkModel("abortHeld");
    init_n = 1'b1;
    stepAndCheck("afterAbort", 1, 77, 0, 0, 8'h00, 0, 0);

    // Counter sequence: halt, restart, 7 RUN edges (2 stalled, the last halting).
    stepAndCheck("cnt.halt0", 0, 0, 0, 0, 8'h00, 1, 0);
    stepAndCheck("cnt.start", 1, 40, 0, 0, 8'h00, 0, 0);
    stepAndCheck("cnt.r1", 0, 0, 0, 0, 8'h00, 0, 0);
    stepAndCheck("cnt.r2", 0, 0, 0, 0, 8'h00, 1, 1);
    stepAndCheck("cnt.r3", 0, 0, 0, 0, 8'h00, 0, 0);
    stepAndCheck("cnt.r4", 0, 0, 1, 1, 8'h10, 0, 1);
    stepAndCheck("cnt.r5", 0, 0, 0, 0, 8'h00, 0, 0);
    stepAndCheck("cnt.r6", 0, 0, 0, 0, 8'h00, 0, 0);
    stepAndCheck("cnt.r7", 0, 0, 0, 0, 8'h00, 1, 0);
    checkOutput("cnt.haltPC", 32'(bus.PC), 32'd44);
    checkOutput("cnt.haltDone", 32'(bus.Done), 32'd1);
`ifdef PC_CYCLE_COUNT_EN
    checkOutput("cnt.held7", 32'(bus.CycleCount), 32'd7);
`endif
    stepAndCheck("cnt.idleDone", 0, 0, 0, 0, 8'h00, 0, 0);
`ifdef PC_CYCLE_COUNT_EN
    checkOutput("cnt.stillHeld7", 32'(bus.CycleCount), 32'd7);
`endif
    stepAndCheck("cnt.restart", 1, 12, 0, 0, 8'h00, 0, 0);
`ifdef PC_CYCLE_COUNT_EN
    checkOutput("cnt.cleared", 32'(bus.CycleCount), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter and sequencing stage of the core. Owns the instruction address, steps it each cycle, and applies taken branches. The branch decision comes from the register file's `BranchDirection` output and the signed offset comes from its `BranchAmount` output. It also runs the start/halt handshake with the testbench or top level. The PC drives instruction memory directly, and that memory's decoded fields feed the register file.

## Interface
- `PC_W`, default 10: PC width in bits; instruction memory depth is 2^PC_W.
- `CLK`, input, 1: the single clock; all state updates on the rising edge.
- `init_n`, input, 1: reset, asynchronous and active-low.
- `Start`, input, 1: level sampled at the clock edge; begins a program run from `StartAddr`.
- `StartAddr`, input, PC_W: first instruction address, loaded on an accepted `Start`.
- `Branch`, input, 1: the current instruction is a conditional branch (decoded from instruction memory at `PC`).
- `BranchDirection`, input, 1: taken flag from the register file (accumulator bit 0); 1 = taken.
- `BranchAmount`, input, 8: signed two's-complement PC offset from the register file's branch-target register.
- `Halt`, input, 1: the current instruction is the halt instruction.
- `Stall`, input, 1: freezes the PC and state for this cycle.
- `PC`, output, PC_W: current instruction address, registered.
- `Running`, output, 1: high while in the RUN state.
- `Done`, output, 1: high while in the DONE state.
- `CycleCount`, output, 16: present only with `PC_CYCLE_COUNT_EN`.

## Operation
- FSM states are IDLE, RUN and DONE. `Running` = (state == RUN). `Done` = (state == DONE).
- Reset (`init_n` = 0, asynchronous):
  - state = IDLE, `PC` = 0, `Running` = 0, `Done` = 0, `CycleCount` = 0.
  - All state is held while `init_n` is low.
- IDLE: when `Start` = 1, load `PC` <= `StartAddr` and go to RUN. Otherwise hold, and `PC` keeps its value.
- RUN: each edge, apply the first matching rule:
  1. `Stall` = 1: `PC` and state hold. `Halt` and `Branch` are ignored this cycle.
  2. `Halt` = 1: go to DONE. `PC` holds at the halt address.
  3. `Branch` = 1 and `BranchDirection` = 1: `PC` <= `PC` + sign_extend(`BranchAmount`), taken modulo 2^PC_W.
  4. Otherwise, including `Branch` = 1 with `BranchDirection` = 0: `PC` <= `PC` + 1, modulo 2^PC_W.
- `Start` is ignored in RUN. A run cannot be restarted until it reaches DONE.
- DONE: `PC` holds. When `Start` = 1, load `PC` <= `StartAddr`, go to RUN, and clear `Done` at the same edge.
- Arithmetic and width rules:
  - `BranchAmount` is sign-extended to PC_W bits before the add.
  - Backward branches below address 0 wrap to the top of memory. Forward branches past the top wrap to the bottom.
  - An offset of 0 re-executes the same instruction; this is legal and is a valid spin loop.
- If `Halt` and `Branch` are both asserted, `Halt` wins.

## Timing
- `PC` changes only on the rising `CLK` edge, or asynchronously to 0 on reset.
- Instruction fetch and decode are combinational from `PC`, so `Branch`, `Halt`, `BranchAmount` and `BranchDirection` all refer to the instruction at the current `PC`.
- Branch latency is one cycle: the target address appears on `PC` the cycle after the branch instruction. There is no delay slot and no bubble.
- Start latency is one cycle: `PC` = `StartAddr` and `Running` = 1 on the edge that samples `Start` = 1.
- `Done` rises on the edge that samples `Halt` = 1 and `Stall` = 0. It stays high until the next accepted `Start`.
- Reset asserted mid-run aborts immediately: IDLE with `PC` = 0. Release of `init_n` is synchronized externally.

## Configuration
- `PC_CYCLE_COUNT_EN` defined:
  - Adds the 16-bit `CycleCount` output.
  - The counter clears to 0 on an accepted `Start` and increments on every edge in RUN, including stalled cycles.
  - It saturates at 16'hFFFF and holds its value in DONE, so it is readable after the halt.
- `PC_CYCLE_COUNT_EN` undefined: the `CycleCount` port and counter are absent. All other behaviour is identical.

## Test plan
- Reset then start:
  - Stimulus: hold `init_n` = 0 for 3 cycles, release, then pulse `Start` with `StartAddr` = 5.
  - Required: `PC` = 0 and `Running` = 0 during reset; the next edge gives `PC` = 5 and `Running` = 1; the following edges give 6, 7.
- Branch taken and not taken:
  - Stimulus: at `PC` = 20, `Branch` = 1 with `BranchAmount` = 8'hFC (-4).
  - Required: `BranchDirection` = 1 gives `PC` = 16 next; `BranchDirection` = 0 gives `PC` = 21.
- Wrap-around:
  - Stimulus 1: `PC` = 1023 with no branch. Required: `PC` = 0.
  - Stimulus 2: `PC` = 2 with a taken branch and `BranchAmount` = 8'hFB (-5). Required: `PC` = 1021.
- Stall and halt priority:
  - Stimulus: at `PC` = 30, assert `Stall` = 1 together with `Halt` = 1 for 2 cycles, then `Stall` = 0.
  - Required: `PC` = 30 and `Running` = 1 throughout the stall; `Done` = 1 one edge after `Stall` drops, with `PC` = 30.
- Halt/branch collision and restart:
  - Stimulus: `Halt` = 1 and a taken `Branch` in the same cycle, then `Start` in DONE with `StartAddr` = 0.
  - Required: DONE is entered with `PC` unchanged; the restart edge gives `PC` = 0, `Done` = 0, `Running` = 1.
- With `PC_CYCLE_COUNT_EN`:
  - Stimulus: run 7 RUN cycles including 2 stalls, then halt.
  - Required: `CycleCount` = 7 held in DONE; it clears to 0 on the next `Start`.
